// File: rtl/aq_jpeg_rgb2ycbcr.sv
// RGB to level-shifted YCbCr for one 8x8 block at a time, into a two-bank ping-pong block buffer.
// Latency: pixel accepted at edge E0 is written to the buffer at E4. Buffer reads return data one cycle after the address.
// Backpressure: InReady drops while both banks hold accepted blocks. The pipeline itself never stalls.
module aq_jpeg_rgb2ycbcr (
  input  logic              clk,
  input  logic              rst,
  input  logic              DataInit,
  input  logic              InValid,
  output logic              InReady,
  input  logic [7:0]        InR,
  input  logic [7:0]        InG,
  input  logic [7:0]        InB,
  input  logic [11:0]       InBlockX,
  input  logic [11:0]       InBlockY,
  output logic              OutValid,
  input  logic [5:0]        OutAddress,
  output logic signed [8:0] OutY,
  output logic signed [8:0] OutCb,
  output logic signed [8:0] OutCr,
  output logic [11:0]       OutBlockX,
  output logic [11:0]       OutBlockY,
  input  logic              OutRelease
);

  // Q14 coefficients and rounding constant
  localparam logic signed [25:0] C_YR  = 26'sd4899;
  localparam logic signed [25:0] C_YG  = 26'sd9617;
  localparam logic signed [25:0] C_YB  = 26'sd1868;
  localparam logic signed [25:0] C_CBR = -26'sd2765;
  localparam logic signed [25:0] C_CBG = -26'sd5427;
  localparam logic signed [25:0] C_CBB = 26'sd8192;
  localparam logic signed [25:0] C_CRR = 26'sd8192;
  localparam logic signed [25:0] C_CRG = -26'sd6860;
  localparam logic signed [25:0] C_CRB = -26'sd1332;
  localparam logic signed [25:0] C_RND = 26'sd8192;

  // Bank accounting
  logic [5:0]  r_acc_cnt;
  logic        r_wr_bank, r_rd_bank;
  logic [1:0]  r_occ, r_full;
  logic [11:0] r_tag_x [2];
  logic [11:0] r_tag_y [2];

  // Pipeline control: valid, in-block address and bank travel with each pixel
  logic        r_s0_vld, r_s1_vld, r_s2_vld, r_s3_vld;
  logic [5:0]  r_s0_addr, r_s1_addr, r_s2_addr, r_s3_addr;
  logic        r_s0_bank, r_s1_bank, r_s2_bank, r_s3_bank;

  // Pipeline data
  logic [7:0]         r_s0_r, r_s0_g, r_s0_b;
  logic signed [25:0] r_p_yr, r_p_yg, r_p_yb, r_p_cbr, r_p_cbg, r_p_cbb, r_p_crr, r_p_crg, r_p_crb;
  logic signed [25:0] r_s2_y, r_s2_cb, r_s2_cr;
  logic signed [8:0]  r_s3_y, r_s3_cb, r_s3_cr;

  // Block buffer: {bank, address} -> {Y, Cb, Cr}
  logic [26:0] r_ram [0:127];
  logic [26:0] w_rd_word;
  logic signed [8:0] r_out_y, r_out_cb, r_out_cr;

  logic w_accept, w_release, w_last_acc, w_last_wr;
  logic signed [25:0] w_r, w_g, w_b;

  assign InReady    = (r_occ < 2'd2);
  assign OutValid   = (r_full != 2'd0);
  assign w_accept   = InValid && InReady;
  assign w_release  = OutRelease && OutValid;
  assign w_last_acc = w_accept && (r_acc_cnt == 6'd63);
  assign w_last_wr  = r_s3_vld && (r_s3_addr == 6'd63);
  assign w_r        = $signed({18'd0, r_s0_r});
  assign w_g        = $signed({18'd0, r_s0_g});
  assign w_b        = $signed({18'd0, r_s0_b});
  assign w_rd_word  = r_ram[{r_rd_bank, OutAddress}];
  assign OutY       = r_out_y;
  assign OutCb      = r_out_cb;
  assign OutCr      = r_out_cr;
  assign OutBlockX  = r_tag_x[r_rd_bank];
  assign OutBlockY  = r_tag_y[r_rd_bank];

  function automatic logic signed [8:0] clamp9(input logic signed [25:0] v);
    if (v > 26'sd127)
      return 9'sd127;
    else if (v < -26'sd128)
      return -9'sd128;
    else
      return v[8:0];
  endfunction

  // Accept counter, bank pointers, occupancy/full counters and block tags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc_cnt  <= 6'd0;
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_occ      <= 2'd0;
      r_full     <= 2'd0;
      r_tag_x[0] <= 12'd0;
      r_tag_x[1] <= 12'd0;
      r_tag_y[0] <= 12'd0;
      r_tag_y[1] <= 12'd0;
    end else if (DataInit) begin
      r_acc_cnt <= 6'd0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_occ     <= 2'd0;
      r_full    <= 2'd0;
    end else begin
      if (w_accept) begin
        r_acc_cnt <= r_acc_cnt + 6'd1;
        if (r_acc_cnt == 6'd0) begin
          r_tag_x[r_wr_bank] <= InBlockX;
          r_tag_y[r_wr_bank] <= InBlockY;
        end
      end
      if (w_last_acc) r_wr_bank <= ~r_wr_bank;
      if (w_release)  r_rd_bank <= ~r_rd_bank;
      // A block entering and one leaving in the same cycle cancel out
      if (w_last_acc && !w_release)      r_occ <= r_occ + 2'd1;
      else if (!w_last_acc && w_release) r_occ <= r_occ - 2'd1;
      if (w_last_wr && !w_release)       r_full <= r_full + 2'd1;
      else if (!w_last_wr && w_release)  r_full <= r_full - 2'd1;
    end
  end

  // Pipeline control shift: valids flushed by DataInit, address/bank follow the pixel
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_vld <= 1'b0; r_s1_vld <= 1'b0; r_s2_vld <= 1'b0; r_s3_vld <= 1'b0;
      r_s0_addr <= 6'd0; r_s1_addr <= 6'd0; r_s2_addr <= 6'd0; r_s3_addr <= 6'd0;
      r_s0_bank <= 1'b0; r_s1_bank <= 1'b0; r_s2_bank <= 1'b0; r_s3_bank <= 1'b0;
    end else begin
      r_s0_vld  <= w_accept && !DataInit;
      r_s1_vld  <= r_s0_vld && !DataInit;
      r_s2_vld  <= r_s1_vld && !DataInit;
      r_s3_vld  <= r_s2_vld && !DataInit;
      r_s0_addr <= r_acc_cnt;  r_s1_addr <= r_s0_addr; r_s2_addr <= r_s1_addr; r_s3_addr <= r_s2_addr;
      r_s0_bank <= r_wr_bank;  r_s1_bank <= r_s0_bank; r_s2_bank <= r_s1_bank; r_s3_bank <= r_s2_bank;
    end
  end

  // Arithmetic pipeline: input register, products, sums + rounding, shift/offset/clamp
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_r <= 8'd0; r_s0_g <= 8'd0; r_s0_b <= 8'd0;
      r_p_yr <= '0; r_p_yg <= '0; r_p_yb <= '0;
      r_p_cbr <= '0; r_p_cbg <= '0; r_p_cbb <= '0;
      r_p_crr <= '0; r_p_crg <= '0; r_p_crb <= '0;
      r_s2_y <= '0; r_s2_cb <= '0; r_s2_cr <= '0;
      r_s3_y <= '0; r_s3_cb <= '0; r_s3_cr <= '0;
    end else begin
      r_s0_r  <= InR;
      r_s0_g  <= InG;
      r_s0_b  <= InB;
      r_p_yr  <= w_r * C_YR;  r_p_yg  <= w_g * C_YG;  r_p_yb  <= w_b * C_YB;
      r_p_cbr <= w_r * C_CBR; r_p_cbg <= w_g * C_CBG; r_p_cbb <= w_b * C_CBB;
      r_p_crr <= w_r * C_CRR; r_p_crg <= w_g * C_CRG; r_p_crb <= w_b * C_CRB;
      r_s2_y  <= r_p_yr + r_p_yg + r_p_yb + C_RND;
      r_s2_cb <= r_p_cbr + r_p_cbg + r_p_cbb + C_RND;
      r_s2_cr <= r_p_crr + r_p_crg + r_p_crb + C_RND;
      r_s3_y  <= clamp9((r_s2_y >>> 14) - 26'sd128);
      r_s3_cb <= clamp9(r_s2_cb >>> 14);
      r_s3_cr <= clamp9(r_s2_cr >>> 14);
    end
  end

  // Buffer write of converted pixels; contents survive reset and DataInit
  always_ff @(posedge clk) begin
    if (r_s3_vld && !DataInit)
      r_ram[{r_s3_bank, r_s3_addr}] <= {r_s3_y, r_s3_cb, r_s3_cr};
  end

  // Registered read of the read bank
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_y  <= 9'sd0;
      r_out_cb <= 9'sd0;
      r_out_cr <= 9'sd0;
    end else begin
      r_out_y  <= w_rd_word[26:18];
      r_out_cb <= w_rd_word[17:9];
      r_out_cr <= w_rd_word[8:0];
    end
  end

endmodule

// File: tb/tb_aq_jpeg_rgb2ycbcr.sv
// Self-checking bench for aq_jpeg_rgb2ycbcr: colour table, ramp block, backpressure, release corners, DataInit, async reset.
// Expected values come from a hand-computed colour table and a real-valued reference of the conversion.
// Inputs are driven on the falling edge; outputs sampled 1 time unit after the rising edge.
module tb_aq_jpeg_rgb2ycbcr;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              DataInit = 1'b0;
  logic              InValid = 1'b0;
  logic              InReady;
  logic [7:0]        InR = 8'd0, InG = 8'd0, InB = 8'd0;
  logic [11:0]       InBlockX = 12'd0, InBlockY = 12'd0;
  logic              OutValid;
  logic [5:0]        OutAddress = 6'd0;
  logic signed [8:0] OutY, OutCb, OutCr;
  logic [11:0]       OutBlockX, OutBlockY;
  logic              OutRelease = 1'b0;

  aq_jpeg_rgb2ycbcr dut (
    .clk(clk), .rst(rst), .DataInit(DataInit),
    .InValid(InValid), .InReady(InReady),
    .InR(InR), .InG(InG), .InB(InB),
    .InBlockX(InBlockX), .InBlockY(InBlockY),
    .OutValid(OutValid), .OutAddress(OutAddress),
    .OutY(OutY), .OutCb(OutCb), .OutCr(OutCr),
    .OutBlockX(OutBlockX), .OutBlockY(OutBlockY),
    .OutRelease(OutRelease)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r, g, b;
    int         y, cb, cr;
  } vec_t;

  vec_t vt [6];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int clampi(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  // Real-valued conversion: floor(sum/16384 + 0.5), Y offset by -128, then clamp
  function automatic int ref_conv(input int r, input int g, input int b, input int sel);
    real s;
    int  q;
    if (sel == 0)      s = 4899.0 * r + 9617.0 * g + 1868.0 * b;
    else if (sel == 1) s = -2765.0 * r - 5427.0 * g + 8192.0 * b;
    else               s = 8192.0 * r - 6860.0 * g - 1332.0 * b;
    q = int'($floor(s / 16384.0 + 0.5));
    if (sel == 0) q = q - 128;
    return clampi(q);
  endfunction

  // kind 0: colour table cycled, kind 1: ramp, kind 2: white
  task automatic pix_of(input int kind, input int i, output logic [7:0] r, output logic [7:0] g, output logic [7:0] b);
    if (kind == 0) begin
      r = vt[i % 6].r; g = vt[i % 6].g; b = vt[i % 6].b;
    end else if (kind == 1) begin
      r = 8'(i * 4); g = 8'(255 - i * 4); b = 8'((i * 37) % 256);
    end else begin
      r = 8'd255; g = 8'd255; b = 8'd255;
    end
  endtask

  task automatic exp_of(input int kind, input int i, output int y, output int cb, output int cr);
    logic [7:0] r, g, b;
    if (kind == 0) begin
      y = vt[i % 6].y; cb = vt[i % 6].cb; cr = vt[i % 6].cr;
    end else if (kind == 2) begin
      y = vt[1].y; cb = vt[1].cb; cr = vt[1].cr;
    end else begin
      pix_of(kind, i, r, g, b);
      y  = ref_conv(r, g, b, 0);
      cb = ref_conv(r, g, b, 1);
      cr = ref_conv(r, g, b, 2);
    end
  endtask

  task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [11:0] bx, input logic [11:0] by);
    int n;
    n = 0;
    @(negedge clk);
    while (!InReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!InReady) begin
      checks++;
      failures++;
      $display("FAIL send_px_timeout InReady actual=0 required=1");
    end
    InR = r; InG = g; InB = b; InBlockX = bx; InBlockY = by;
    InValid = 1'b1;
    @(posedge clk);
    #1 InValid = 1'b0;
  endtask

  task automatic send_pixels(input int kind, input int first, input int count, input logic [11:0] bx, input logic [11:0] by);
    logic [7:0] r, g, b;
    for (int i = first; i < first + count; i++) begin
      pix_of(kind, i % 64, r, g, b);
      send_px(r, g, b, bx, by);
    end
  endtask

  task automatic read_px(input int a, output int y, output int cb, output int cr);
    @(negedge clk);
    OutAddress = 6'(a);
    @(posedge clk);
    #1;
    y = OutY; cb = OutCb; cr = OutCr;
  endtask

  task automatic check_block(input int kind, input string tag);
    int y, cb, cr, ey, ecb, ecr;
    for (int a = 0; a < 64; a++) begin
      read_px(a, y, cb, cr);
      exp_of(kind, a, ey, ecb, ecr);
      chk($sformatf("%s_y[%0d]", tag, a), y, ey);
      chk($sformatf("%s_cb[%0d]", tag, a), cb, ecb);
      chk($sformatf("%s_cr[%0d]", tag, a), cr, ecr);
    end
  endtask

  task automatic release_blk();
    @(negedge clk);
    OutRelease = 1'b1;
    @(posedge clk);
    #1 OutRelease = 1'b0;
  endtask

  task automatic data_init();
    @(negedge clk);
    DataInit = 1'b1;
    @(posedge clk);
    #1 DataInit = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int y, cb, cr;
    // Hand-computed colour points
    vt[0] = '{r: 8'd128, g: 8'd128, b: 8'd128, y:    0, cb:   0, cr:    0};
    vt[1] = '{r: 8'd255, g: 8'd255, b: 8'd255, y:  127, cb:   0, cr:    0};
    vt[2] = '{r: 8'd255, g: 8'd0,   b: 8'd0,   y:  -52, cb: -43, cr:  127};
    vt[3] = '{r: 8'd0,   g: 8'd0,   b: 8'd255, y:  -99, cb: 127, cr:  -21};
    vt[4] = '{r: 8'd0,   g: 8'd0,   b: 8'd0,   y: -128, cb:   0, cr:    0};
    vt[5] = '{r: 8'd0,   g: 8'd255, b: 8'd0,   y:   22, cb: -84, cr: -107};

    // Reset state
    #2 rst = 1'b0;
    #20;
    chk("rst_InReady", InReady, 1);
    chk("rst_OutValid", OutValid, 0);
    chk("rst_OutY", OutY, 0);
    chk("rst_OutCb", OutCb, 0);
    chk("rst_OutCr", OutCr, 0);
    chk("rst_OutBlockX", OutBlockX, 0);
    chk("rst_OutBlockY", OutBlockY, 0);
    @(negedge clk);
    rst = 1'b1;

    // Colour-table block with OutValid latency
    send_pixels(0, 0, 64, 12'd5, 12'd7);
    repeat (3) @(posedge clk);
    #1 chk("ov_after_e3", OutValid, 0);
    @(posedge clk);
    #1 chk("ov_after_e4", OutValid, 1);
    chk("blk1_InReady", InReady, 1);
    chk("blk1_tagx", OutBlockX, 5);
    chk("blk1_tagy", OutBlockY, 7);
    check_block(0, "tbl");
    release_blk();
    chk("blk1_rel_OutValid", OutValid, 0);
    chk("blk1_rel_InReady", InReady, 1);

    // Ramp block: address mapping and tag
    send_pixels(1, 0, 64, 12'hABC, 12'h123);
    wait_cycles(5);
    chk("ramp_OutValid", OutValid, 1);
    chk("ramp_tagx", OutBlockX, 12'hABC);
    chk("ramp_tagy", OutBlockY, 12'h123);
    check_block(1, "ramp");
    release_blk();
    chk("ramp_rel_OutValid", OutValid, 0);

    // Backpressure: two full blocks and no release
    send_pixels(1, 0, 64, 12'd1, 12'd1);
    send_pixels(1, 0, 64, 12'd2, 12'd2);
    chk("bp_InReady_low", InReady, 0);
    wait_cycles(5);
    chk("bp_InReady_still_low", InReady, 0);
    chk("bp_OutValid", OutValid, 1);
    chk("bp_tag1", OutBlockX, 1);
    release_blk();
    chk("bp_InReady_after_rel", InReady, 1);
    chk("bp_OutValid_after_rel", OutValid, 1);
    chk("bp_tag2", OutBlockX, 2);
    check_block(1, "bp2");
    send_pixels(1, 0, 2, 12'd3, 12'd3);
    chk("bp_InReady_partial", InReady, 1);
    release_blk();
    chk("bp_OutValid_drained", OutValid, 0);
    data_init();

    // DataInit after 30 pixels of a block
    send_pixels(2, 0, 30, 12'd9, 12'd9);
    data_init();
    chk("di_OutValid", OutValid, 0);
    chk("di_InReady", InReady, 1);
    send_pixels(0, 0, 63, 12'd4, 12'd4);
    wait_cycles(5);
    chk("di_OutValid_63px", OutValid, 0);
    send_pixels(0, 63, 1, 12'd4, 12'd4);
    wait_cycles(5);
    chk("di_OutValid_full", OutValid, 1);
    chk("di_tagx", OutBlockX, 4);
    check_block(0, "di");
    release_blk();

    // Release while OutValid is low is ignored
    release_blk();
    chk("idle_rel_OutValid", OutValid, 0);
    chk("idle_rel_InReady", InReady, 1);

    // Release coincident with the last write of the next block
    send_pixels(2, 0, 64, 12'd7, 12'd7);
    wait_cycles(5);
    chk("co_tagA", OutBlockX, 7);
    send_pixels(0, 0, 64, 12'd8, 12'd8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    OutRelease = 1'b1;
    @(posedge clk);
    #1 OutRelease = 1'b0;
    chk("co_OutValid", OutValid, 1);
    chk("co_tagB", OutBlockX, 8);
    chk("co_InReady", InReady, 1);
    check_block(0, "co");
    release_blk();
    chk("co_drained", OutValid, 0);

    // Asynchronous reset mid-stream
    send_pixels(2, 0, 64, 12'd6, 12'd6);
    wait_cycles(5);
    read_px(0, y, cb, cr);
    chk("ar_pre_y", y, 127);
    chk("ar_pre_tag", OutBlockX, 6);
    send_pixels(1, 0, 10, 12'd11, 12'd11);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ar_InReady", InReady, 1);
    chk("ar_OutValid", OutValid, 0);
    chk("ar_OutY", OutY, 0);
    chk("ar_OutCb", OutCb, 0);
    chk("ar_OutCr", OutCr, 0);
    chk("ar_OutBlockX", OutBlockX, 0);
    chk("ar_OutBlockY", OutBlockY, 0);
    @(negedge clk);
    rst = 1'b1;
    send_pixels(1, 0, 64, 12'd3, 12'd5);
    wait_cycles(5);
    chk("ar_resume_OutValid", OutValid, 1);
    chk("ar_resume_tagx", OutBlockX, 3);
    chk("ar_resume_tagy", OutBlockY, 5);
    check_block(1, "ar");
    release_blk();
    chk("ar_resume_drained", OutValid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aq_jpeg_rgb2ycbcr.md
# aq_jpeg_rgb2ycbcr

Colour-conversion front end of the JPEG encoder, mirroring the decoder's YCbCr→RGB stage. Accepts 8-bit RGB pixels one 8x8 block at a time (4:4:4, raster order within the block), converts them to level-shifted signed Y/Cb/Cr with a 3-stage Q14 fixed-point pipeline, and stores them in a two-bank ping-pong block buffer. The forward DCT reads completed blocks by address and releases each bank when finished.

## Interface
- No parameters.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- DataInit  in  1  synchronous flush of pipeline, counters and bank state
- InValid  in  1  pixel present on InR/InG/InB
- InReady  out  1  block accepts a pixel this cycle
- InR, InG, InB  in  8 each  unsigned pixel components
- InBlockX, InBlockY  in  12 each  block coordinates, sampled with pixel 0 of each block
- OutValid  out  1  read bank holds a complete block
- OutAddress  in  6  read address, 0..63, raster within block
- OutY, OutCb, OutCr  out  9 each  signed, range -128..127, registered read data
- OutBlockX, OutBlockY  out  12 each  coordinates of the block in the read bank
- OutRelease  in  1  one-cycle pulse: read bank consumed

## Operation
- Accept: InValid && InReady at a clock edge. Accept counter (6-bit) gives pixel address; wraps 63→0 and toggles write-bank pointer on pixel 63. InBlockX/Y latched into write bank's tag on pixel 0.
- Coefficients (Q14): Y = 4899R + 9617G + 1868B; Cb = -2765R - 5427G + 8192B; Cr = 8192R - 6860G - 1332B. Products signed, sums held in 26-bit signed.
- Rounding: add 8192, arithmetic shift right 14 (floor). Y then minus 128. Clamp all three to [-128, 127] (Cb/Cr reach +128 for saturated blue/red; clamp to 127).
- Pipeline: stage 1 products, stage 2 sums + rounding constant, stage 3 shift/offset/clamp; result written to buffer on the following edge at the address carried with the pixel. Pipeline advances every cycle (no internal stall; throttling is only via InReady).
- Bank accounting: occ (0..2) increments on acceptance of pixel 63, decrements on accepted release. full (0..2) increments when pixel 63 is written to RAM, decrements on accepted release. InReady = (occ < 2). OutValid = (full > 0). Read bank pointer toggles on accepted release.
- OutRelease accepted only when OutValid=1; otherwise ignored (no counter change).
- Simultaneous increment and release in one cycle: counter unchanged, both pointer updates occur.
- Read port: OutY/Cb/Cr registered from read bank at OutAddress; OutBlockX/Y combinational from read bank tag.
- DataInit: clears accept counter, both bank pointers, occ, full, pipeline valids; partially accepted block discarded. RAM contents are not cleared. DataInit wins over simultaneous accept/release.

## Timing
- Reset values: InReady 1 (occ=0), OutValid 0, OutY/OutCb/OutCr 0, OutBlockX/Y 0; all counters/pointers 0.
- Conversion latency: pixel accepted at edge E0 is in RAM after edge E4.
- OutValid rises the cycle after edge E4 of pixel 63 (4 cycles after its acceptance edge).
- Read latency: 1 cycle, OutAddress at edge N → data valid after edge N.
- InReady falls the cycle after the edge accepting pixel 63 when occ becomes 2; rises the cycle after an accepted OutRelease.
- OutValid falls the cycle after release if full becomes 0.
- Throughput: one pixel per cycle sustained while the reader releases at least one block per 64 cycles.
- After DataInit: InReady 1 and OutValid 0 from the next cycle.

## Test plan
- Gray block, all pixels (128,128,128) → after release of nothing, OutValid after 64+4 cycles; every address reads Y=0, Cb=0, Cr=0.
- Colour points: white (255,255,255) → (127,0,0); red (255,0,0) → Y=-52, Cb=-43, Cr=127 (clamped from 128); blue (0,0,255) → Y=-99, Cb=127 (clamped), Cr=-21; black → (-128,0,0). Raster ramp block verifies address mapping and InBlockX/Y tag.
- Backpressure: stream 130 pixels with no release → InReady low after 128th accept, OutValid high; pulse OutRelease → InReady high next cycle, second block's tag presented, remaining pixels accepted.
- Release with OutValid=0 → no state change; release coincident with pixel-63 write → full stays 1, read pointer toggles, next block readable.
- DataInit asserted after 30 pixels of a block → OutValid 0, InReady 1; next 64 pixels form a complete block at bank 0 with correct data.
- Asynchronous reset mid-stream → all outputs at reset values immediately; normal operation resumes after release.
